// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Load/store initiator between the pipeline M stage and a byte-enabled
//   word data memory. Takes one request per handshake, checks alignment,
//   drives the memory strobes, and returns a one-cycle response.
//   Stores get byte enables and lane-replicated write data. Loads wait
//   READ_LAT cycles, then the selected lane is extracted and sign- or
//   zero-extended.
//
// Ports
//   clk, reset                    clock (rising edge), async active-high reset
//   req_valid/req_ready           request handshake (ready only while idle)
//   req_we/size/signed/addr/
//   req_wdata/req_pc              request fields, latched on acceptance
//   mem_a/wd/be/we/re, mem_rd     data memory interface
//   rsp_valid/rdata/err/
//   rsp_badaddr/rsp_pc            one-cycle response
//   busy                          high whenever the controller is not idle
//
// Every output is a flop. The flops are loaded from values computed for the
// next state, so each strobe appears in the cycle the FSM occupies the
// matching state.

module mem_access_ctrl #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rd,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] rsp_badaddr,
  output logic [31:0] rsp_pc,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_cnt;
  logic [1:0]  r_addrLo;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_pc;

  logic        w_accept;
  logic        w_reqErr;
  logic [31:0] w_memA;
  logic [31:0] w_memWd;
  logic [3:0]  w_memBe;
  logic        w_memWe;
  logic        w_memRe;
  logic        w_rspValid;
  logic [31:0] w_rspRdata;
  logic        w_rspErr;
  logic [31:0] w_rspBadaddr;
  logic [31:0] w_rspPc;
  logic        w_reqReady;
  logic        w_busy;

  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] writeData(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] loadData(input logic [1:0] size, input logic [1:0] lo,
                                           input logic sgn, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: return rd;
    endcase
  endfunction

  assign w_accept = req_valid && (r_state == IDLE);

  // Size 11 and misaligned half/word addresses never reach memory.
  always_comb begin
    case (req_size)
      2'b00:   w_reqErr = 1'b0;
      2'b01:   w_reqErr = req_addr[0];
      2'b10:   w_reqErr = (req_addr[1:0] != 2'b00);
      default: w_reqErr = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = w_reqErr ? RESP : (req_we ? WRITE : READ);
      WRITE:   w_nextState = RESP;
      READ:    w_nextState = WAIT;
      WAIT:    if (r_cnt == 3'd1) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output values for the coming cycle. Memory address/data/enables hold
  // their last values unless a new access is being launched. An error
  // response is produced straight from IDLE, so it takes its fields from the
  // live request rather than the latches.
  always_comb begin
    w_memA       = mem_a;
    w_memWd      = mem_wd;
    w_memBe      = mem_be;
    w_memWe      = 1'b0;
    w_memRe      = 1'b0;
    w_rspValid   = 1'b0;
    w_rspRdata   = 32'd0;
    w_rspErr     = 1'b0;
    w_rspBadaddr = 32'd0;
    w_rspPc      = 32'd0;
    if (w_accept && !w_reqErr) begin
      w_memA  = {req_addr[31:2], 2'b00};
      w_memBe = byteEnable(req_size, req_addr[1:0]);
      if (req_we) begin
        w_memWd = writeData(req_size, req_wdata);
        w_memWe = 1'b1;
      end else begin
        w_memRe = 1'b1;
      end
    end
    if (w_nextState == RESP) begin
      w_rspValid = 1'b1;
      if (r_state == IDLE) begin
        w_rspErr     = 1'b1;
        w_rspBadaddr = req_addr;
        w_rspPc      = req_pc;
      end else begin
        w_rspPc = r_pc;
        if (r_state == WAIT) w_rspRdata = loadData(r_size, r_addrLo, r_signed, mem_rd);
      end
    end
    w_reqReady = (w_nextState == IDLE);
    w_busy     = !w_reqReady;
  end

  // Registered outputs; reset drops every strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_a       <= 32'd0;
      mem_wd      <= 32'd0;
      mem_be      <= 4'd0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
      rsp_badaddr <= 32'd0;
      rsp_pc      <= 32'd0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      mem_a       <= w_memA;
      mem_wd      <= w_memWd;
      mem_be      <= w_memBe;
      mem_we      <= w_memWe;
      mem_re      <= w_memRe;
      rsp_valid   <= w_rspValid;
      rsp_rdata   <= w_rspRdata;
      rsp_err     <= w_rspErr;
      rsp_badaddr <= w_rspBadaddr;
      rsp_pc      <= w_rspPc;
      req_ready   <= w_reqReady;
      busy        <= w_busy;
    end
  end

  // Request latches and read-latency counter. The counter holds READ_LAT on
  // the first WAIT cycle, so reaching 1 marks the cycle mem_rd is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 3'd0;
      r_addrLo <= 2'd0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_pc     <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addrLo <= req_addr[1:0];
        r_size   <= req_size;
        r_signed <= req_signed;
        r_pc     <= req_pc;
      end
      if (r_state == READ)      r_cnt <= 3'(READ_LAT);
      else if (r_state == WAIT) r_cnt <= r_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Drives three controllers (READ_LAT 1, 2 and 7) from one request stream.
//   Each has its own memory model that returns rdData exactly READ_LAT
//   cycles after mem_re and 32'hDEADBEEF otherwise. Most scenarios check the
//   READ_LAT=2 instance (index 1); the latency sweep compares 1 and 7.

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [31:0] reqPc;
  logic [31:0] rdData;

  logic        reqReady   [3];
  logic [31:0] memA       [3];
  logic [31:0] memWd      [3];
  logic [3:0]  memBe      [3];
  logic        memWe      [3];
  logic        memRe      [3];
  logic [31:0] memRd      [3];
  logic        rspValid   [3];
  logic [31:0] rspRdata   [3];
  logic        rspErr     [3];
  logic [31:0] rspBadaddr [3];
  logic [31:0] rspPc      [3];
  logic        busy       [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 7);
    logic [7:0] rePipe;

    mem_access_ctrl #(.READ_LAT(L)) dut (
      .clk(clk), .reset(reset),
      .req_valid(reqValid), .req_ready(reqReady[g]),
      .req_we(reqWe), .req_size(reqSize), .req_signed(reqSigned),
      .req_addr(reqAddr), .req_wdata(reqWdata), .req_pc(reqPc),
      .mem_a(memA[g]), .mem_wd(memWd[g]), .mem_be(memBe[g]),
      .mem_we(memWe[g]), .mem_re(memRe[g]), .mem_rd(memRd[g]),
      .rsp_valid(rspValid[g]), .rsp_rdata(rspRdata[g]), .rsp_err(rspErr[g]),
      .rsp_badaddr(rspBadaddr[g]), .rsp_pc(rspPc[g]), .busy(busy[g])
    );

    // Memory model: read data is only valid READ_LAT cycles after mem_re.
    always @(posedge clk or posedge reset) begin
      if (reset) rePipe <= 8'd0;
      else       rePipe <= {rePipe[6:0], memRe[g]};
    end
    assign memRd[g] = rePipe[L-1] ? rdData : 32'hDEADBEEF;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle (cycle T); returns in cycle T+1.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
    reqWe = we; reqSize = size; reqSigned = sgn;
    reqAddr = addr; reqWdata = wdata; reqPc = pc;
    reqValid = 1'b1;
    tick();
    reqValid = 1'b0;
  endtask

  task automatic waitIdle;
    int n = 0;
    while ((busy[0] || busy[1] || busy[2]) && n < 60) begin
      tick();
      n++;
    end
    checks++; if (busy[0] || busy[1] || busy[2]) begin failures++; $display("[TB] FAIL idle_timeout busy still high after %0d cycles, required 0", n); end
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    checks++; if (reqReady[1] !== 1'b1) begin failures++; $display("[TB] FAIL rst_req_ready got=%0h exp=1", reqReady[1]); end
    checks++; if (busy[1] !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%0h exp=0", busy[1]); end
    checks++; if (memWe[1] !== 1'b0 || memRe[1] !== 1'b0) begin failures++; $display("[TB] FAIL rst_strobes got=%0h%0h exp=00", memWe[1], memRe[1]); end
    checks++; if (rspValid[1] !== 1'b0) begin failures++; $display("[TB] FAIL rst_rsp_valid got=%0h exp=0", rspValid[1]); end
    checks++; if (memA[1] !== 32'd0 || memBe[1] !== 4'd0) begin failures++; $display("[TB] FAIL rst_mem_a_be got=%h/%b exp=0/0000", memA[1], memBe[1]); end
    checks++; if (rspPc[1] !== 32'd0) begin failures++; $display("[TB] FAIL rst_rsp_pc got=%h exp=0", rspPc[1]); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_store;
    issue(1'b1, 2'b00, 1'b0, 32'h3, 32'h123456AB, 32'h100);
    checks++; if (memWe[1] !== 1'b1) begin failures++; $display("[TB] FAIL st_mem_we got=%0h exp=1", memWe[1]); end
    checks++; if (memRe[1] !== 1'b0) begin failures++; $display("[TB] FAIL st_mem_re got=%0h exp=0", memRe[1]); end
    checks++; if (memA[1] !== 32'h0) begin failures++; $display("[TB] FAIL st_mem_a got=%h exp=00000000", memA[1]); end
    checks++; if (memBe[1] !== 4'b1000) begin failures++; $display("[TB] FAIL st_mem_be got=%b exp=1000", memBe[1]); end
    checks++; if (memWd[1] !== 32'hABABABAB) begin failures++; $display("[TB] FAIL st_mem_wd got=%h exp=abababab", memWd[1]); end
    checks++; if (reqReady[1] !== 1'b0 || rspValid[1] !== 1'b0) begin failures++; $display("[TB] FAIL st_t1_ready_rsp got=%0h%0h exp=00", reqReady[1], rspValid[1]); end
    tick();
    checks++; if (rspValid[1] !== 1'b1 || rspErr[1] !== 1'b0) begin failures++; $display("[TB] FAIL st_rsp got valid=%0h err=%0h exp valid=1 err=0", rspValid[1], rspErr[1]); end
    checks++; if (rspPc[1] !== 32'h100 || rspRdata[1] !== 32'h0) begin failures++; $display("[TB] FAIL st_rsp_pc_rdata got=%h/%h exp=00000100/00000000", rspPc[1], rspRdata[1]); end
    checks++; if (memWe[1] !== 1'b0) begin failures++; $display("[TB] FAIL st_we_one_cycle got=%0h exp=0", memWe[1]); end
    tick();
    checks++; if (rspValid[1] !== 1'b0 || reqReady[1] !== 1'b1) begin failures++; $display("[TB] FAIL st_after_rsp got valid=%0h ready=%0h exp 0/1", rspValid[1], reqReady[1]); end
    checks++; if (memBe[1] !== 4'b1000 || memWd[1] !== 32'hABABABAB) begin failures++; $display("[TB] FAIL st_hold got=%b/%h exp=1000/abababab", memBe[1], memWd[1]); end
    waitIdle();
    issue(1'b1, 2'b01, 1'b0, 32'h2, 32'hAAAA1234, 32'h104);
    checks++; if (memBe[1] !== 4'b1100 || memWd[1] !== 32'h12341234) begin failures++; $display("[TB] FAIL st_half got=%b/%h exp=1100/12341234", memBe[1], memWd[1]); end
    waitIdle();
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h89ABCDEF, 32'h108);
    checks++; if (memBe[1] !== 4'b1111 || memWd[1] !== 32'h89ABCDEF || memA[1] !== 32'h8) begin failures++; $display("[TB] FAIL st_word got=%b/%h/%h exp=1111/89abcdef/00000008", memBe[1], memWd[1], memA[1]); end
    waitIdle();
  endtask

  task automatic test_half_load;
    rdData = 32'h80017FFF;
    issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h200);
    checks++; if (memRe[1] !== 1'b1 || memWe[1] !== 1'b0) begin failures++; $display("[TB] FAIL ld_strobes got re=%0h we=%0h exp re=1 we=0", memRe[1], memWe[1]); end
    checks++; if (memA[1] !== 32'h4 || memBe[1] !== 4'b1100) begin failures++; $display("[TB] FAIL ld_addr_be got=%h/%b exp=00000004/1100", memA[1], memBe[1]); end
    tick();
    checks++; if (memRe[1] !== 1'b0 || rspValid[1] !== 1'b0) begin failures++; $display("[TB] FAIL ld_t2 got re=%0h rsp=%0h exp 0/0", memRe[1], rspValid[1]); end
    tick();
    checks++; if (rspValid[1] !== 1'b0) begin failures++; $display("[TB] FAIL ld_t3_rsp got=%0h exp=0", rspValid[1]); end
    tick();
    checks++; if (rspValid[1] !== 1'b1 || rspRdata[1] !== 32'hFFFF8001) begin failures++; $display("[TB] FAIL ld_signed got valid=%0h rdata=%h exp 1/ffff8001", rspValid[1], rspRdata[1]); end
    checks++; if (rspPc[1] !== 32'h200 || rspErr[1] !== 1'b0) begin failures++; $display("[TB] FAIL ld_pc_err got=%h/%0h exp=00000200/0", rspPc[1], rspErr[1]); end
    waitIdle();
    issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'h204);
    tick(); tick(); tick();
    checks++; if (rspValid[1] !== 1'b1 || rspRdata[1] !== 32'h00008001) begin failures++; $display("[TB] FAIL ld_unsigned got valid=%0h rdata=%h exp 1/00008001", rspValid[1], rspRdata[1]); end
    waitIdle();
  endtask

  task automatic test_misaligned;
    issue(1'b0, 2'b10, 1'b0, 32'h5, 32'h0, 32'h300);
    checks++; if (rspValid[1] !== 1'b1 || rspErr[1] !== 1'b1) begin failures++; $display("[TB] FAIL mis_rsp got valid=%0h err=%0h exp 1/1", rspValid[1], rspErr[1]); end
    checks++; if (rspBadaddr[1] !== 32'h5 || rspPc[1] !== 32'h300) begin failures++; $display("[TB] FAIL mis_badaddr_pc got=%h/%h exp=00000005/00000300", rspBadaddr[1], rspPc[1]); end
    checks++; if (memRe[1] !== 1'b0 || memWe[1] !== 1'b0 || rspRdata[1] !== 32'h0) begin failures++; $display("[TB] FAIL mis_no_strobe got re=%0h we=%0h rdata=%h exp 0/0/0", memRe[1], memWe[1], rspRdata[1]); end
    tick();
    checks++; if (memRe[1] !== 1'b0 || rspValid[1] !== 1'b0 || rspErr[1] !== 1'b0 || rspBadaddr[1] !== 32'h0) begin failures++; $display("[TB] FAIL mis_t2 got re=%0h v=%0h e=%0h ba=%h exp all 0", memRe[1], rspValid[1], rspErr[1], rspBadaddr[1]); end
    checks++; if (reqReady[1] !== 1'b1) begin failures++; $display("[TB] FAIL mis_ready got=%0h exp=1", reqReady[1]); end
    waitIdle();
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h304);
    checks++; if (rspErr[1] !== 1'b1 || rspPc[1] !== 32'h304 || memRe[1] !== 1'b0) begin failures++; $display("[TB] FAIL mis_size11 got err=%0h pc=%h re=%0h exp 1/00000304/0", rspErr[1], rspPc[1], memRe[1]); end
    waitIdle();
    issue(1'b1, 2'b01, 1'b0, 32'h1, 32'hFFFF, 32'h308);
    checks++; if (rspErr[1] !== 1'b1 || rspBadaddr[1] !== 32'h1 || memWe[1] !== 1'b0) begin failures++; $display("[TB] FAIL mis_half_store got err=%0h ba=%h we=%0h exp 1/00000001/0", rspErr[1], rspBadaddr[1], memWe[1]); end
    waitIdle();
  endtask

  task automatic test_back_to_back;
    int rspCount = 0;
    rdData = 32'hCAFEF00D;
    reqWe = 1'b0; reqSize = 2'b10; reqSigned = 1'b0;
    reqAddr = 32'h10; reqWdata = 32'h0; reqPc = 32'h400;
    reqValid = 1'b1;
    tick();
    reqWe = 1'b1; reqSize = 2'b00; reqAddr = 32'h11; reqWdata = 32'h55; reqPc = 32'h404;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (reqReady[1] !== 1'b0 || rspValid[1] !== 1'b0) begin failures++; $display("[TB] FAIL b2b_inflight_%0d got ready=%0h rsp=%0h exp 0/0", k, reqReady[1], rspValid[1]); end
      if (rspValid[1]) rspCount++;
      tick();
    end
    checks++; if (reqReady[1] !== 1'b0 || rspValid[1] !== 1'b1 || rspRdata[1] !== 32'hCAFEF00D || rspPc[1] !== 32'h400) begin failures++; $display("[TB] FAIL b2b_rsp1 got ready=%0h v=%0h rdata=%h pc=%h exp 0/1/cafef00d/00000400", reqReady[1], rspValid[1], rspRdata[1], rspPc[1]); end
    if (rspValid[1]) rspCount++;
    tick();
    checks++; if (reqReady[1] !== 1'b1 || rspValid[1] !== 1'b0) begin failures++; $display("[TB] FAIL b2b_t5 got ready=%0h rsp=%0h exp 1/0", reqReady[1], rspValid[1]); end
    if (rspValid[1]) rspCount++;
    tick();
    reqValid = 1'b0;
    checks++; if (memWe[1] !== 1'b1 || memBe[1] !== 4'b0010 || memWd[1] !== 32'h55555555 || memA[1] !== 32'h10) begin failures++; $display("[TB] FAIL b2b_store got we=%0h be=%b wd=%h a=%h exp 1/0010/55555555/00000010", memWe[1], memBe[1], memWd[1], memA[1]); end
    if (rspValid[1]) rspCount++;
    tick();
    checks++; if (rspValid[1] !== 1'b1 || rspPc[1] !== 32'h404 || rspRdata[1] !== 32'h0) begin failures++; $display("[TB] FAIL b2b_rsp2 got v=%0h pc=%h rdata=%h exp 1/00000404/0", rspValid[1], rspPc[1], rspRdata[1]); end
    for (int k = 7; k <= 10; k++) begin
      if (rspValid[1]) rspCount++;
      tick();
    end
    checks++; if (rspCount != 2) begin failures++; $display("[TB] FAIL b2b_rsp_count got=%0d exp=2", rspCount); end
    waitIdle();
  endtask

  task automatic test_reset_mid_access;
    int strayRsp = 0;
    rdData = 32'h12345678;
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h500);
    reset = 1'b1;
    #1;
    checks++; if (memRe[0] !== 1'b0 || memRe[1] !== 1'b0 || memRe[2] !== 1'b0) begin failures++; $display("[TB] FAIL rst_read_re got=%0h%0h%0h exp=000", memRe[0], memRe[1], memRe[2]); end
    tick();
    reset = 1'b0;
    tick();
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h504);
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++; if (memRe[1] !== 1'b0 || memRe[2] !== 1'b0 || rspValid[0] !== 1'b0 || rspValid[1] !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait got re=%0h%0h rsp=%0h%0h exp 00/00", memRe[1], memRe[2], rspValid[0], rspValid[1]); end
    checks++; if (busy[2] !== 1'b0 || reqReady[2] !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait_idle got busy=%0h ready=%0h exp 0/1", busy[2], reqReady[2]); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (rspValid[0] || rspValid[1] || rspValid[2]) strayRsp++;
      tick();
    end
    checks++; if (strayRsp != 0) begin failures++; $display("[TB] FAIL rst_abandon got=%0d responses exp=0", strayRsp); end
    rdData = 32'h0000FF00;
    issue(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 32'h508);
    checks++; if (memBe[1] !== 4'b0010 || memA[1] !== 32'h0) begin failures++; $display("[TB] FAIL rst_byte_be got=%b/%h exp=0010/00000000", memBe[1], memA[1]); end
    tick(); tick(); tick();
    checks++; if (rspValid[1] !== 1'b1 || rspRdata[1] !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL rst_byte_load got v=%0h rdata=%h exp 1/ffffffff", rspValid[1], rspRdata[1]); end
    waitIdle();
  endtask

  task automatic test_latency_sweep;
    int cyc0 = 0, cyc2 = 0, cnt0 = 0, cnt2 = 0, re0 = 0, re2 = 0;
    logic [31:0] rd0 = 32'h0, rd2 = 32'h0;
    rdData = 32'h000000A5;
    issue(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h600);
    for (int k = 1; k <= 11; k++) begin
      if (rspValid[0]) begin cnt0++; cyc0 = k; rd0 = rspRdata[0]; end
      if (rspValid[2]) begin cnt2++; cyc2 = k; rd2 = rspRdata[2]; end
      re0 += int'(memRe[0]);
      re2 += int'(memRe[2]);
      tick();
    end
    checks++; if (cyc0 != 3 || cnt0 != 1) begin failures++; $display("[TB] FAIL lat1_timing got cycle=T+%0d count=%0d exp T+3/1", cyc0, cnt0); end
    checks++; if (cyc2 != 9 || cnt2 != 1) begin failures++; $display("[TB] FAIL lat7_timing got cycle=T+%0d count=%0d exp T+9/1", cyc2, cnt2); end
    checks++; if (re0 != 1 || re2 != 1) begin failures++; $display("[TB] FAIL lat_re_pulses got=%0d/%0d exp=1/1", re0, re2); end
    checks++; if (rd0 !== 32'hA5 || rd2 !== 32'hA5) begin failures++; $display("[TB] FAIL lat_rdata got=%h/%h exp=000000a5/000000a5", rd0, rd2); end
    waitIdle();
  endtask

  initial begin
    reset = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = 32'h0; reqWdata = 32'h0; reqPc = 32'h0; rdData = 32'h0;
    test_reset();
    test_store();
    test_half_load();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    test_latency_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
